// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with programmable modulus, prescaler,
// synchronous load/clear, and wrap or saturate behaviour at the boundaries.

module bcd_updown_digit (
    input  logic       up,
    input  logic       cin,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_updown_counter #(
    parameter int DIGITS    = 3,
    parameter int MAX_COUNT = 999,
    parameter int PRESCALE  = 1,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  wrap,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic [DIGITS-1:0][3:0] cur;
    logic [DIGITS-1:0][3:0] nxt;
    logic [DIGITS:0]        carry;
    logic [DIGITS-1:0]      dig_ok;
    logic                   load_ok;
    logic                   psc_hit;
    logic                   step;

    assign cur      = count;
    assign carry[0] = 1'b1;

    // Ripple carry/borrow chain: a digit moves only when all lower digits rolled.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_updown_digit u_dig (
            .up   (up_dn),
            .cin  (carry[i]),
            .d    (cur[i]),
            .q    (nxt[i]),
            .cout (carry[i+1])
        );
        assign dig_ok[i] = (load_val[4*i +: 4] <= 4'd9);
    end

    // With all digits valid, packed-BCD ordering matches numeric ordering.
    assign load_ok = (&dig_ok) && (load_val <= MAX_BCD);

    if (PRESCALE > 1) begin : g_psc
        localparam int PW = $clog2(PRESCALE);
        logic [PW-1:0] psc;
        assign psc_hit = (psc == PW'(PRESCALE - 1));
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                psc <= '0;
            else if (load || clr)
                psc <= '0;
            else if (en)
                psc <= psc_hit ? '0 : psc + PW'(1);
        end
    end else begin : g_nopsc
        assign psc_hit = 1'b1;
    end

    assign step = en && !load && !clr && psc_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) count    <= load_val;
                else         load_err <= 1'b1;
            end else if (clr) begin
                count <= '0;
            end else if (step) begin
                if (up_dn) begin
                    if (count != MAX_BCD) begin
                        count <= nxt;
                    end else if (WRAP != 0) begin
                        count <= '0;
                        wrap  <= 1'b1;
                    end
                end else begin
                    if (count != '0) begin
                        count <= nxt;
                    end else if (WRAP != 0) begin
                        count <= MAX_BCD;
                        wrap  <= 1'b1;
                    end
                end
            end
        end
    end

    assign at_max  = (count == MAX_BCD);
    assign at_zero = (count == '0);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench over four counter configurations: 3-digit wrap, 2-digit mod-60,
// 3-digit saturating, and 3-digit with a divide-by-4 prescaler.

module tb_bcd_updown_counter;
    logic        clk;
    logic        rst;
    logic        en    [4];
    logic        up_dn [4];
    logic        clr   [4];
    logic        load  [4];
    logic [11:0] lv    [4];
    logic [11:0] cnt   [4];
    logic        am    [4];
    logic        az    [4];
    logic        wr    [4];
    logic        le    [4];
    logic [7:0]  cnt_b;
    logic [7:0]  lv_b;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cnt[1] = {4'h0, cnt_b};
    assign lv_b   = lv[1][7:0];

    bcd_updown_counter #(.DIGITS(3), .MAX_COUNT(999), .PRESCALE(1), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .up_dn(up_dn[0]), .clr(clr[0]), .load(load[0]),
        .load_val(lv[0]), .count(cnt[0]), .at_max(am[0]), .at_zero(az[0]), .wrap(wr[0]),
        .load_err(le[0]));

    bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(59), .PRESCALE(1), .WRAP(1)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .up_dn(up_dn[1]), .clr(clr[1]), .load(load[1]),
        .load_val(lv_b), .count(cnt_b), .at_max(am[1]), .at_zero(az[1]), .wrap(wr[1]),
        .load_err(le[1]));

    bcd_updown_counter #(.DIGITS(3), .MAX_COUNT(999), .PRESCALE(1), .WRAP(0)) u_c (
        .clk(clk), .rst(rst), .en(en[2]), .up_dn(up_dn[2]), .clr(clr[2]), .load(load[2]),
        .load_val(lv[2]), .count(cnt[2]), .at_max(am[2]), .at_zero(az[2]), .wrap(wr[2]),
        .load_err(le[2]));

    bcd_updown_counter #(.DIGITS(3), .MAX_COUNT(999), .PRESCALE(4), .WRAP(1)) u_d (
        .clk(clk), .rst(rst), .en(en[3]), .up_dn(up_dn[3]), .clr(clr[3]), .load(load[3]),
        .load_val(lv[3]), .count(cnt[3]), .at_max(am[3]), .at_zero(az[3]), .wrap(wr[3]),
        .load_err(le[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int i, input logic [11:0] v);
        load[i] = 1'b1;
        lv[i]   = v;
        tick();
        load[i] = 1'b0;
    endtask

    task automatic stp(input int i, input logic d);
        up_dn[i] = d;
        en[i]    = 1'b1;
        tick();
        en[i]    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0; up_dn[i] = 1'b1; clr[i] = 1'b0; load[i] = 1'b0; lv[i] = '0;
        end
        tick(); tick();
        chk("rst_cnt", 32'(cnt[0]), 32'h000);
        chk("rst_zero", 32'(az[0]), 32'd1);
        chk("rst_max", 32'(am[0]), 32'd0);
        chk("rst_wrap", 32'(wr[0]), 32'd0);
        rst = 1'b1;
        tick();

        // async reset between edges, prescaler left mid-phase in u_d
        ld(0, 12'h123);
        chk("ld_123", 32'(cnt[0]), 32'h123);
        en[3] = 1'b1; up_dn[3] = 1'b1;
        tick(); tick();
        en[3] = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_cnt", 32'(cnt[0]), 32'h000);
        chk("async_zero", 32'(az[0]), 32'd1);
        tick();
        rst = 1'b1;

        // prescaler restarted from 0: steps on en cycles 4, 8, 12
        en[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("psc_k%0d", k), 32'(cnt[3]), 32'(k / 4));
        end
        en[3] = 1'b0;
        ld(3, 12'h1A3);
        chk("rej_err", 32'(le[3]), 32'd1);
        chk("rej_cnt", 32'(cnt[3]), 32'h003);
        tick();
        chk("rej_pulse", 32'(le[3]), 32'd0);
        en[3] = 1'b1; clr[3] = 1'b1;
        ld(3, 12'h045);
        en[3] = 1'b0; clr[3] = 1'b0;
        chk("ld_over_clr", 32'(cnt[3]), 32'h045);

        // 3-digit wrapping counter
        ld(0, 12'h199); stp(0, 1'b1);
        chk("carry_199", 32'(cnt[0]), 32'h200);
        ld(0, 12'h999);
        chk("max_flag", 32'(am[0]), 32'd1);
        stp(0, 1'b1);
        chk("wrap_up_cnt", 32'(cnt[0]), 32'h000);
        chk("wrap_up_w", 32'(wr[0]), 32'd1);
        tick();
        chk("wrap_up_1cyc", 32'(wr[0]), 32'd0);
        ld(0, 12'h100); stp(0, 1'b0);
        chk("borrow_100", 32'(cnt[0]), 32'h099);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("clr_cnt", 32'(cnt[0]), 32'h000);
        chk("clr_nowrap", 32'(wr[0]), 32'd0);
        stp(0, 1'b0);
        chk("wrap_dn_cnt", 32'(cnt[0]), 32'h999);
        chk("wrap_dn_w", 32'(wr[0]), 32'd1);
        tick();
        chk("wrap_dn_1cyc", 32'(wr[0]), 32'd0);
        ld(0, 12'h09A);
        chk("bad_digit_err", 32'(le[0]), 32'd1);
        chk("bad_digit_cnt", 32'(cnt[0]), 32'h999);

        // 2-digit mod-60
        ld(1, 12'h058); stp(1, 1'b1);
        chk("m60_59", 32'(cnt[1]), 32'h59);
        chk("m60_max", 32'(am[1]), 32'd1);
        stp(1, 1'b1);
        chk("m60_wrap_cnt", 32'(cnt[1]), 32'h00);
        chk("m60_wrap_w", 32'(wr[1]), 32'd1);
        stp(1, 1'b0);
        chk("m60_dn_cnt", 32'(cnt[1]), 32'h59);
        chk("m60_dn_w", 32'(wr[1]), 32'd1);
        ld(1, 12'h060);
        chk("m60_rej_err", 32'(le[1]), 32'd1);
        chk("m60_rej_cnt", 32'(cnt[1]), 32'h59);

        // saturating counter
        ld(2, 12'h999);
        en[2] = 1'b1; up_dn[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_up_cnt", 32'(cnt[2]), 32'h999);
            chk("sat_up_w", 32'(wr[2]), 32'd0);
        end
        en[2] = 1'b0;
        ld(2, 12'h000); stp(2, 1'b0);
        chk("sat_dn_cnt", 32'(cnt[2]), 32'h000);
        chk("sat_dn_w", 32'(wr[2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
